// File: rtl/ccff_pkg.sv
// rtl/ccff_pkg.sv - shared state type, default marker and counter width helpers
package ccff_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MARK = 2'd1,
    DATA = 2'd2,
    FIN  = 2'd3
  } state_t;

  localparam logic [7:0] DEFAULT_MARKER = 8'hA5;

  function automatic int sc_width(input int mark_len, input int chain_len);
    return $clog2(mark_len + chain_len + 1);
  endfunction

  function automatic int cnt_width(input int word_w);
    return $clog2(word_w + 1);
  endfunction

endpackage

// File: rtl/ccff_word_serializer.sv
// rtl/ccff_word_serializer.sv - word buffer feeding one configuration bit per take
// Stops requesting once CHAIN_LEN bits are buffered; surplus bits of the last word are dropped.
module ccff_word_serializer
  import ccff_pkg::*;
#(
  parameter int CHAIN_LEN = 24,
  parameter int WORD_W    = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_arm,
  input  logic              i_word_valid,
  input  logic [WORD_W-1:0] i_word_data,
  output logic              o_word_ready,
  output logic              o_bit,
  output logic              o_bit_valid,
  input  logic              i_bit_take
);

  localparam int CNT_W = cnt_width(WORD_W);
  localparam int REM_W = $clog2(CHAIN_LEN + 1);

  logic [WORD_W-1:0] r_buf;
  logic [CNT_W-1:0]  r_cnt;
  logic [REM_W-1:0]  r_unloaded;
  logic              w_load;
  logic [CNT_W-1:0]  w_load_cnt;

  assign o_bit       = r_buf[0];
  assign o_bit_valid = (r_cnt != '0);

  // Refill in the same edge the last buffered bit leaves, so streaming has no bubble.
  assign o_word_ready = (r_unloaded != '0) &&
                        ((r_cnt == '0) || ((r_cnt == CNT_W'(1)) && i_bit_take));
  assign w_load       = o_word_ready && i_word_valid;
  assign w_load_cnt   = (32'(r_unloaded) >= 32'(WORD_W)) ? CNT_W'(WORD_W) : CNT_W'(r_unloaded);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_buf      <= '0;
      r_cnt      <= '0;
      r_unloaded <= '0;
    end else if (i_arm) begin
      r_cnt      <= '0;
      r_unloaded <= REM_W'(CHAIN_LEN);
    end else if (w_load) begin
      r_buf      <= i_word_data;
      r_cnt      <= w_load_cnt;
      r_unloaded <= r_unloaded - REM_W'(w_load_cnt);
    end else if (i_bit_take) begin
      r_buf <= r_buf >> 1;
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/ccff_chain_loader.sv
// rtl/ccff_chain_loader.sv - marker-prefixed serial loader for a ccff configuration chain
// Outputs are registered one cycle ahead: the bit on ccff_head shifts at the end of its cycle.
module ccff_chain_loader
  import ccff_pkg::*;
#(
  parameter int                  CHAIN_LEN = 24,
  parameter int                  WORD_W    = 8,
  parameter int                  MARK_LEN  = 8,
  parameter logic [MARK_LEN-1:0] MARKER    = MARK_LEN'(DEFAULT_MARKER)
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic              word_valid,
  input  logic [WORD_W-1:0] word_data,
  output logic              word_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int TOTAL = MARK_LEN + CHAIN_LEN;
  localparam int SC_W  = sc_width(MARK_LEN, CHAIN_LEN);

  state_t              r_state;
  logic [SC_W-1:0]     r_sc;
  logic [MARK_LEN-1:0] r_mark_sh;
  logic [MARK_LEN-1:0] r_chk_sh;
  logic                r_head;
  logic                r_en;
  logic                r_busy;
  logic                r_done;
  logic                r_err;

  logic [SC_W-1:0]     w_issued;
  logic                w_data_slot;
  logic                w_take;
  logic                w_arm;
  logic                w_chk;
  logic                w_bit;
  logic                w_bit_valid;

  // Bits already placed on ccff_head, counting the one shifting this cycle.
  assign w_issued    = r_sc + SC_W'(r_en);
  assign w_data_slot = ((r_state == MARK) && (w_issued == SC_W'(MARK_LEN))) ||
                       ((r_state == DATA) && (w_issued <  SC_W'(TOTAL)));
  assign w_take      = w_data_slot && w_bit_valid;
  assign w_arm       = (r_state == IDLE) && start;
  assign w_chk       = r_en && (r_sc >= SC_W'(CHAIN_LEN)) && (r_sc < SC_W'(TOTAL));

  ccff_word_serializer #(
    .CHAIN_LEN (CHAIN_LEN),
    .WORD_W    (WORD_W)
  ) u_ser (
    .i_clk        (prog_clk),
    .i_rst        (pReset),
    .i_arm        (w_arm),
    .i_word_valid (word_valid),
    .i_word_data  (word_data),
    .o_word_ready (word_ready),
    .o_bit        (w_bit),
    .o_bit_valid  (w_bit_valid),
    .i_bit_take   (w_take)
  );

  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      r_state   <= IDLE;
      r_sc      <= '0;
      r_mark_sh <= '0;
      r_chk_sh  <= '0;
      r_head    <= 1'b0;
      r_en      <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      if (r_en) r_sc <= r_sc + SC_W'(1);
      // Marker bits reappear on ccff_tail after exactly CHAIN_LEN shifts.
      if (w_chk) begin
        if (ccff_tail != r_chk_sh[0]) r_err <= 1'b1;
        r_chk_sh <= r_chk_sh >> 1;
      end
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state   <= MARK;
            r_busy    <= 1'b1;
            r_err     <= 1'b0;
            r_sc      <= '0;
            r_head    <= MARKER[0];
            r_en      <= 1'b1;
            r_mark_sh <= MARKER >> 1;
            r_chk_sh  <= MARKER;
          end
        end
        MARK: begin
          if (w_issued < SC_W'(MARK_LEN)) begin
            r_head    <= r_mark_sh[0];
            r_mark_sh <= r_mark_sh >> 1;
            r_en      <= 1'b1;
          end else begin
            r_state <= DATA;
            r_en    <= w_take;
            if (w_take) r_head <= w_bit;
          end
        end
        DATA: begin
          if (w_issued == SC_W'(TOTAL)) begin
            r_state <= FIN;
            r_en    <= 1'b0;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_en <= w_take;
            if (w_take) r_head <= w_bit;
          end
        end
        FIN: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ccff_head     = r_head;
  assign ccff_shift_en = r_en;
  assign busy          = r_busy;
  assign done          = r_done;
  assign error         = r_err;

endmodule
